md_issue_ctrl: RTL and testbench
================================

# md_issue_ctrl

Pipeline-side initiator for the HI/LO multiply/divide unit. It accepts one MD instruction per handshake from the E stage and drives the unit's start, operand, HI/LO-write and cancel inputs. It waits on the unit's `busy` line and returns `mfhi`/`mflo` read data to the pipeline. It sits between the E-stage decode/forwarding logic and the multiply/divide unit, and produces the MD-related pipeline stall.

## Interface
- `WAIT_MAX`, default 31: cycles in WAIT before a timeout is declared; 5-bit counter.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: E stage presents an MD instruction.
- `req_op` input 4: operation code. 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MFHI, 6=MFLO, 7=MTHI, 8=MTLO; other values are treated as no-op.
- `req_rs` input 32: forwarded rs value.
- `req_rt` input 32: forwarded rt value.
- `req_ready` output 1: request accepted this cycle when asserted together with `req_valid`.
- `flush` input 1: exception/interrupt flush from CP0.
- `md_busy` input 1: unit `busy`.
- `md_hi` input 32: unit HI register.
- `md_lo` input 32: unit LO register.
- `md_cal` output 2: unit start code. 01=mult, 10=div, 00=none.
- `md_signed` output 1: unit `is_signed`.
- `md_reg_wr` output 2: unit HI/LO write select. 01=HI, 10=LO, 00=none.
- `md_a` output 32: unit inputA.
- `md_b` output 32: unit inputB.
- `md_ext_int` output 2: unit cancel control. 01=BEGIN (restore HI/LO, abort), 00=idle.
- `resp_valid` output 1: one-cycle pulse when the accepted instruction completes.
- `resp_data` output 32: MFHI/MFLO result. Valid with `resp_valid`; otherwise 0.
- `stall` output 1: `req_valid & ~req_ready`.
- `timeout` output 1: sticky; set on a WAIT timeout, cleared only by `reset`.

## Operation
- States are IDLE, START, WAIT, MOVE, READ and DONE.
- `req_ready` = (state==IDLE) & ~`md_busy` & ~`flush`.
- On handshake in IDLE:
  - MULT/MULTU/DIV/DIVU: latch rs, rt and the signed bit (MULT/DIV signed) into registers; go to START.
  - MTHI/MTLO: latch rs; go to MOVE.
  - MFHI/MFLO: go to READ.
  - Invalid op: go to DONE with `resp_data`=0.
- START (one cycle): drive `md_cal` (01 for MULT/MULTU, 10 for DIV/DIVU), `md_a`/`md_b` = latched rs/rt, and `md_signed`; go to WAIT and clear the wait counter.
- WAIT: `md_cal`=00 and operands held. Exit to DONE on the first cycle `md_busy`=0. The counter increments each WAIT cycle; when it reaches `WAIT_MAX`, set `timeout` and go to DONE.
- MOVE (one cycle): `md_reg_wr` = 01 (MTHI) or 10 (MTLO), `md_a` = latched rs; go to DONE.
- READ (one cycle): capture `md_hi` (MFHI) or `md_lo` (MFLO) into the result register; go to DONE.
- DONE (one cycle): `resp_valid`=1, `resp_data` = result register (0 for non-read ops); go to IDLE.
- `flush` in any state:
  - Overrides the transition: next state is IDLE.
  - `md_ext_int`=01 for exactly the cycle `flush` is high; `md_cal` and `md_reg_wr` are forced to 00 that cycle.
  - No `resp_valid` for the flushed instruction.
- `flush` in the same cycle as `req_valid`: no handshake.
- `reset`: state=IDLE. All outputs are 0 except that `req_ready` follows its equation. The result, operand and counter registers are cleared and `timeout` is cleared.

## Timing
- Handshake at edge N. MULT: `md_cal` high in cycle N+1, WAIT from N+2, `resp_valid` the cycle after `md_busy` is first seen low.
- With a 5-cycle multiplier, `resp_valid` is at N+8. With a 10-cycle divider, it is at N+13.
- MFHI/MFLO: READ at N+1, `resp_valid` at N+2, carrying HI/LO as sampled at N+1.
- MTHI/MTLO: `md_reg_wr` at N+1, `resp_valid` at N+2.
- Back-to-back: the next handshake is at the earliest in the cycle after DONE, and only if `md_busy`=0.
- Every unit-facing output is registered, so there is no combinational path from `req_*` to `md_*`.

## Configuration
- `MD_DIV0_SKIP_EN` defined: DIV/DIVU with `req_rt`==0 is not issued. The FSM goes IDLE→DONE directly, `resp_valid` fires at N+1, and HI/LO are left untouched.
- `MD_DIV0_SKIP_EN` undefined: divide by zero is issued like any other DIV.

## Test plan
- `reset` held 2 cycles → `resp_valid`=0, `md_cal`=0, `md_ext_int`=0, `timeout`=0 and `req_ready`=1 with `md_busy`=0.
- MULT rs=0xFFFFFFFE, rt=3 against a 5-cycle unit model → `md_cal`=01 and `md_signed`=1 for exactly one cycle. `resp_valid` at N+8. `stall`=1 while a second request waits.
- MTLO rs=0x1234, then MFLO → `md_reg_wr`=10 with `md_a`=0x1234 for one cycle. MFLO then returns `resp_data`=0x1234.
- DIVU rs=7, rt=2; `flush` in WAIT → `md_ext_int`=01 for one cycle, no `resp_valid`, state IDLE, and a new request is accepted the next cycle once busy is low.
- `md_busy` stuck at 1 after START → after 31 WAIT cycles, `timeout`=1 (sticky) and `resp_valid` pulses once.
- DIV rt=0: with `MD_DIV0_SKIP_EN`, `md_cal` stays 00 and `resp_valid` fires at N+1. Without the macro, `md_cal`=10 is issued.

Source files
------------

// File: rtl/md_issue_if.sv
// Handshake and unit-facing signal bundle for md_issue_ctrl.
// master: the issue controller; slave: the E stage plus multiply/divide unit.
interface md_issue_if;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_rs;
  logic [31:0] req_rt;
  logic        req_ready;
  logic        flush;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic [1:0]  md_cal;
  logic        md_signed;
  logic [1:0]  md_reg_wr;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [1:0]  md_ext_int;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        stall;
  logic        timeout;

  modport master (
    input  req_valid, req_op, req_rs, req_rt, flush, md_busy, md_hi, md_lo,
    output req_ready, md_cal, md_signed, md_reg_wr, md_a, md_b, md_ext_int,
           resp_valid, resp_data, stall, timeout
  );

  modport slave (
    output req_valid, req_op, req_rs, req_rt, flush, md_busy, md_hi, md_lo,
    input  req_ready, md_cal, md_signed, md_reg_wr, md_a, md_b, md_ext_int,
           resp_valid, resp_data, stall, timeout
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue FSM between the E stage and the HI/LO multiply/divide unit.
// Optional MD_DIV0_SKIP_EN: divides with a zero divisor complete without issuing.
module md_issue_ctrl #(
  parameter int WAIT_MAX = 31
) (
  input  logic       clk,
  input  logic       reset,
  md_issue_if.master bus,
  output logic [2:0] dbg_state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_MOVE  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [4:0] WAIT_LAST = 5'(WAIT_MAX - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [1:0]  md_cal_q, md_cal_d;
  logic        md_signed_q, md_signed_d;
  logic [1:0]  md_reg_wr_q, md_reg_wr_d;

  logic req_ready;
  logic handshake;
  logic is_div_op;

  assign req_ready = (state_q == S_IDLE) & ~bus.md_busy & ~bus.flush;
  assign handshake = bus.req_valid & req_ready;
  assign is_div_op = (bus.req_op == OP_DIV) | (bus.req_op == OP_DIVU);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    result_d   = result_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          op_d     = bus.req_op;
          result_d = '0;
          case (bus.req_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              rs_d    = bus.req_rs;
              rt_d    = bus.req_rt;
              state_d = S_START;
`ifdef MD_DIV0_SKIP_EN
              if (is_div_op && (bus.req_rt == '0)) state_d = S_DONE;
`endif
            end
            OP_MTHI, OP_MTLO: begin
              rs_d    = bus.req_rs;
              state_d = S_MOVE;
            end
            OP_MFHI, OP_MFLO: state_d = S_READ;
            default:          state_d = S_DONE;
          endcase
        end
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.md_busy) begin
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 5'd1;
          if (wait_cnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_MOVE: state_d = S_DONE;
      S_READ: begin
        result_d = (op_q == OP_MFHI) ? bus.md_hi : bus.md_lo;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) state_d = S_IDLE;
  end

  // Unit-facing strobes are decoded from the next state so they come straight from flops.
  always_comb begin
    md_cal_d    = 2'b00;
    md_signed_d = 1'b0;
    md_reg_wr_d = 2'b00;
    if (state_d == S_START) begin
      md_cal_d    = ((op_d == OP_DIV) || (op_d == OP_DIVU)) ? 2'b10 : 2'b01;
      md_signed_d = (op_d == OP_MULT) || (op_d == OP_DIV);
    end
    if (state_d == S_MOVE) begin
      md_reg_wr_d = (op_d == OP_MTHI) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      result_q    <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      md_cal_q    <= 2'b00;
      md_signed_q <= 1'b0;
      md_reg_wr_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      result_q    <= result_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      md_cal_q    <= md_cal_d;
      md_signed_q <= md_signed_d;
      md_reg_wr_q <= md_reg_wr_d;
    end
  end

  // Flush is the only input allowed to reach the unit combinationally: it cancels this cycle.
  assign bus.req_ready  = req_ready;
  assign bus.stall      = bus.req_valid & ~req_ready;
  assign bus.md_cal     = md_cal_q & {2{~bus.flush}};
  assign bus.md_reg_wr  = md_reg_wr_q & {2{~bus.flush}};
  assign bus.md_signed  = md_signed_q;
  assign bus.md_a       = rs_q;
  assign bus.md_b       = rt_q;
  assign bus.md_ext_int = {1'b0, bus.flush & ~reset};
  assign bus.resp_valid = (state_q == S_DONE) & ~bus.flush;
  assign bus.resp_data  = bus.resp_valid ? result_q : '0;
  assign bus.timeout    = timeout_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small multiply/divide unit model.
// Build with +define+MD_DIV0_SKIP_EN to exercise the zero-divisor skip.
module tb_md_issue_ctrl;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  int         vec_cnt;
  int         err_cnt;

  md_issue_if bus();

  md_issue_ctrl #(.WAIT_MAX(31)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unit model: mult 5 cycles, div 10 cycles, HI/LO commit on completion, cancel drops it.
  logic [3:0]  unit_cnt;
  logic        stuck;
  logic [31:0] hi_m, lo_m, phi, plo;
  logic [63:0] prod;

  always_comb begin
    if (bus.md_signed)
      prod = {{32{bus.md_a[31]}}, bus.md_a} * {{32{bus.md_b[31]}}, bus.md_b};
    else
      prod = {32'd0, bus.md_a} * {32'd0, bus.md_b};
  end

  always @(posedge clk) begin
    if (reset) begin
      unit_cnt <= '0;
      hi_m <= '0; lo_m <= '0; phi <= '0; plo <= '0;
    end else if (bus.md_ext_int == 2'b01) begin
      unit_cnt <= '0;
    end else begin
      if (bus.md_cal == 2'b01) begin
        unit_cnt <= 4'd5;
        {phi, plo} <= prod;
      end else if (bus.md_cal == 2'b10) begin
        unit_cnt <= 4'd10;
        phi <= (bus.md_b == 0) ? bus.md_a : bus.md_a % bus.md_b;
        plo <= (bus.md_b == 0) ? 32'hFFFF_FFFF : bus.md_a / bus.md_b;
      end else if (unit_cnt == 4'd1) begin
        unit_cnt <= '0;
        hi_m <= phi;
        lo_m <= plo;
      end else if (unit_cnt != 0) begin
        unit_cnt <= unit_cnt - 4'd1;
      end
      if (bus.md_reg_wr == 2'b01) hi_m <= bus.md_a;
      else if (bus.md_reg_wr == 2'b10) lo_m <= bus.md_a;
    end
  end

  assign bus.md_busy = stuck | (unit_cnt != 0);
  assign bus.md_hi   = hi_m;
  assign bus.md_lo   = lo_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_rs    = rs;
    bus.req_rt    = rt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    stuck   = 1'b0;
    reset   = 1'b1;
    bus.flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);

    // Reset held two cycles
    tick(); tick();
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_md_cal", {30'd0, bus.md_cal}, 32'd0);
    chk("rst_ext_int", {30'd0, bus.md_ext_int}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    // MULT -2 * 3, second request (MFHI) stalls behind it
    drive(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
    #1;
    chk("mult_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();                                   // N+1
    drive(1'b1, 4'd5, 32'd0, 32'd0);
    #1;
    chk("mult_cal", {30'd0, bus.md_cal}, 32'd1);
    chk("mult_signed", {31'd0, bus.md_signed}, 32'd1);
    chk("mult_a", bus.md_a, 32'hFFFF_FFFE);
    chk("mult_b", bus.md_b, 32'd3);
    chk("mult_stall", {31'd0, bus.stall}, 32'd1);
    tick();                                   // N+2
    chk("mult_cal_off", {30'd0, bus.md_cal}, 32'd0);
    chk("mult_signed_off", {31'd0, bus.md_signed}, 32'd0);
    chk("mult_wait_state", {29'd0, dbg_state}, 32'd2);
    for (int i = 0; i < 5; i++) tick();       // N+7
    chk("mult_no_resp_n7", {31'd0, bus.resp_valid}, 32'd0);
    tick();                                   // N+8
    chk("mult_resp_n8", {31'd0, bus.resp_valid}, 32'd1);
    chk("mult_resp_data", bus.resp_data, 32'd0);
    chk("mult_stall_done", {31'd0, bus.stall}, 32'd1);
    tick();                                   // IDLE, MFHI accepted at next edge
    chk("mfhi_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    chk("mfhi_read_state", {29'd0, dbg_state}, 32'd4);
    tick();
    chk("mfhi_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("mfhi_data", bus.resp_data, 32'hFFFF_FFFF);
    tick();
    chk("mfhi_resp_off", {31'd0, bus.resp_valid}, 32'd0);

    // MTLO 0x1234 then MFLO
    drive(1'b1, 4'd8, 32'h1234, 32'd0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    chk("mtlo_reg_wr", {30'd0, bus.md_reg_wr}, 32'd2);
    chk("mtlo_a", bus.md_a, 32'h1234);
    tick();
    chk("mtlo_reg_wr_off", {30'd0, bus.md_reg_wr}, 32'd0);
    chk("mtlo_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("mtlo_resp_data", bus.resp_data, 32'd0);
    tick();
    drive(1'b1, 4'd6, 32'd0, 32'd0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk("mflo_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("mflo_data", bus.resp_data, 32'h1234);
    tick();

    // Flush together with a request: no handshake
    drive(1'b1, 4'd7, 32'hDEAD, 32'd0);
    bus.flush = 1'b1;
    #1;
    chk("flush_req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    chk("flush_req_state", {29'd0, dbg_state}, 32'd0);
    chk("flush_req_reg_wr", {30'd0, bus.md_reg_wr}, 32'd0);

    // DIVU 7/2 flushed in WAIT
    drive(1'b1, 4'd4, 32'd7, 32'd2);
    tick();                                   // START
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    chk("divu_cal", {30'd0, bus.md_cal}, 32'd2);
    chk("divu_signed", {31'd0, bus.md_signed}, 32'd0);
    tick(); tick();                           // WAIT, busy
    bus.flush = 1'b1;
    #1;
    chk("divu_ext_int", {30'd0, bus.md_ext_int}, 32'd1);
    chk("divu_flush_cal", {30'd0, bus.md_cal}, 32'd0);
    chk("divu_flush_resp", {31'd0, bus.resp_valid}, 32'd0);
    tick();
    bus.flush = 1'b0;
    drive(1'b1, 4'd6, 32'd0, 32'd0);
    #1;
    chk("divu_ext_int_off", {30'd0, bus.md_ext_int}, 32'd0);
    chk("divu_idle", {29'd0, dbg_state}, 32'd0);
    chk("divu_next_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("divu_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    tick();                                   // READ of MFLO
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    chk("divu_no_resp_read", {31'd0, bus.resp_valid}, 32'd0);
    tick();
    chk("lo_restored_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("lo_restored_data", bus.resp_data, 32'h1234);
    tick();

    // MULTU with busy stuck high: timeout after 31 WAIT cycles
    drive(1'b1, 4'd2, 32'd5, 32'd6);
    tick();                                   // N+1 START
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    stuck = 1'b1;
    for (int i = 0; i < 31; i++) tick();      // N+32, last WAIT cycle
    chk("to_last_wait", {29'd0, dbg_state}, 32'd2);
    chk("to_not_yet", {31'd0, bus.timeout}, 32'd0);
    tick();                                   // N+33 DONE
    chk("to_set", {31'd0, bus.timeout}, 32'd1);
    chk("to_resp", {31'd0, bus.resp_valid}, 32'd1);
    tick();
    stuck = 1'b0;
    chk("to_resp_once", {31'd0, bus.resp_valid}, 32'd0);
    tick(); tick();
    chk("to_sticky", {31'd0, bus.timeout}, 32'd1);

    // DIV by zero
    drive(1'b1, 4'd3, 32'd9, 32'd0);
    tick();                                   // N+1
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
`ifdef MD_DIV0_SKIP_EN
    chk("div0_cal", {30'd0, bus.md_cal}, 32'd0);
    chk("div0_resp_n1", {31'd0, bus.resp_valid}, 32'd1);
    tick();
    chk("div0_resp_off", {31'd0, bus.resp_valid}, 32'd0);
    chk("div0_idle", {29'd0, dbg_state}, 32'd0);
`else
    chk("div0_cal", {30'd0, bus.md_cal}, 32'd2);
    chk("div0_signed", {31'd0, bus.md_signed}, 32'd1);
    chk("div0_resp_n1", {31'd0, bus.resp_valid}, 32'd0);
    for (int i = 0; i < 11; i++) tick();      // N+12
    chk("div0_no_resp_n12", {31'd0, bus.resp_valid}, 32'd0);
    tick();                                   // N+13
    chk("div0_resp_n13", {31'd0, bus.resp_valid}, 32'd1);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
